// File: rtl/sreg_pkg.sv
// sreg_pkg: shared types and constants for the sreg_xfer frame shifter.
//   state_t        : FSM states (IDLE waits for a frame, SHIFT serialises it)
//   DIR_LSB_FIRST  : word 0 is transmitted first
//   DIR_MSB_FIRST  : word N-1 is transmitted first
package sreg_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/sreg_xfer.sv
// sreg_xfer: full-duplex N-word frame shifter with valid/ready load and per-frame direction.
//   clk, rstn             : clock, asynchronous active-low reset
//   load_valid/load_ready : parallel frame handshake; load_data word i = bits [(i+1)*W-1:i*W]
//   dir                   : 0 = word 0 first, 1 = word N-1 first (sampled on load)
//   en                    : shift enable (only meaningful while busy)
//   si / so, so_valid     : serial word in / registered serial word out, out updated this edge
//   cap_data, cap_valid   : last fully received frame, one-cycle update pulse
//   busy                  : frame in progress
module sreg_xfer
    import sreg_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [N*W-1:0] load_data,
    input  logic           dir,
    input  logic           en,
    input  logic [W-1:0]   si,
    output logic [W-1:0]   so,
    output logic           so_valid,
    output logic [N*W-1:0] cap_data,
    output logic           cap_valid,
    output logic           busy
);
    localparam int CW = $clog2(N);

    state_t               state, state_n;
    logic [N-1:0][W-1:0]  ff, up, dn, nxt;
    logic                 dir_q;
    logic [CW-1:0]        cnt;
    logic                 last;

    // up: array moves toward word 0 (LSB-first), si enters at N-1.
    // dn: array moves toward word N-1 (MSB-first), si enters at 0.
    for (genvar i = 0; i < N; i++) begin : g_nb
        if (i == N-1) begin : g_top
            assign up[i] = si;
        end else begin : g_mid_up
            assign up[i] = ff[i+1];
        end
        if (i == 0) begin : g_bot
            assign dn[i] = si;
        end else begin : g_mid_dn
            assign dn[i] = ff[i-1];
        end
    end

    assign nxt  = (dir_q == DIR_MSB_FIRST) ? dn : up;
    assign last = cnt == CW'(N-1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        load_ready = state == IDLE;
        busy       = state == SHIFT;
        state_n    = (state == IDLE) ? (load_valid ? SHIFT : IDLE)
                                     : ((en && last) ? IDLE : SHIFT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff        <= '0;
            dir_q     <= 1'b0;
            cnt       <= '0;
            so        <= '0;
            so_valid  <= 1'b0;
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            so_valid  <= 1'b0;
            cap_valid <= 1'b0;
            if (state == IDLE && load_valid) begin
                ff    <= load_data;
                dir_q <= dir;
                cnt   <= '0;
            end
            if (state == SHIFT && en) begin
                so       <= (dir_q == DIR_MSB_FIRST) ? ff[N-1] : ff[0];
                ff       <= nxt;
                so_valid <= 1'b1;
                // Counter returns to 0 on the final shift rather than wrapping.
                cnt      <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    cap_data  <= nxt;
                    cap_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sreg_xfer.sv
// tb_sreg_xfer: scoreboard bench for sreg_xfer (N=4, W=8) with directed frames.
module tb_sreg_xfer;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [N*W-1:0] load_data = '0;
    logic           dir = 1'b0;
    logic           en = 1'b0;
    logic [W-1:0]   si = '0;
    logic [W-1:0]   so;
    logic           so_valid;
    logic [N*W-1:0] cap_data;
    logic           cap_valid;
    logic           busy;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]   exp_so[$];
    logic [N*W-1:0] exp_cap[$];

    sreg_xfer #(.N(N), .W(W)) dut (
        .clk(clk), .rstn(rstn), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .dir(dir), .en(en), .si(si), .so(so), .so_valid(so_valid),
        .cap_data(cap_data), .cap_valid(cap_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a word or a frame.
    always @(negedge clk) begin
        if (rstn && so_valid) begin
            if (exp_so.size() == 0) chk("so_unexpected", {31'd0, so_valid}, 32'd0);
            else chk("so", {24'd0, so}, {24'd0, exp_so.pop_front()});
        end
        if (rstn && cap_valid) begin
            if (exp_cap.size() == 0) chk("cap_unexpected", {31'd0, cap_valid}, 32'd0);
            else chk("cap_data", cap_data, exp_cap.pop_front());
        end
    end

    // pat bit k = en for shift edge k; so_seq byte j = j-th word expected on so;
    // si_w byte j = j-th word fed on si. hog keeps a DEADBEEF load offered during the frame.
    task automatic run_frame(input logic [31:0] d, input logic dr, input logic [31:0] si_w,
                             input logic [6:0] pat, input int len, input logic [31:0] so_seq,
                             input logic [31:0] cap, input logic hog);
        int sent = 0;
        for (int j = 0; j < N; j++) exp_so.push_back(so_seq[8*j +: 8]);
        exp_cap.push_back(cap);
        load_valid = 1'b1;
        load_data  = d;
        dir        = dr;
        en         = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_load", {31'd0, load_ready}, 32'd0);
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        chk("cap_valid_single", {31'd0, cap_valid}, 32'd0);
        load_valid = hog;
        load_data  = 32'hDEADBEEF;
        dir        = ~dr;
        for (int k = 0; k < len; k++) begin
            en = pat[k];
            si = pat[k] ? si_w[8*sent +: 8] : 8'h5A;
            @(posedge clk); #1;
            if (pat[k]) sent++;
            chk("so_valid", {31'd0, so_valid}, {31'd0, pat[k]});
            if (!pat[k] && sent > 0) chk("so_hold", {24'd0, so}, {24'd0, so_seq[8*(sent-1) +: 8]});
            chk("load_ready", {31'd0, load_ready}, {31'd0, k == len-1});
            chk("busy", {31'd0, busy}, {31'd0, k != len-1});
        end
        en = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_frame(32'h44332211, 1'b0, 32'hA3A2A1A0, 7'h0F, 4, 32'h44332211, 32'hA3A2A1A0, 1'b0);
        run_frame(32'h44332211, 1'b1, 32'hA3A2A1A0, 7'h0F, 4, 32'h11223344, 32'hA0A1A2A3, 1'b0);
        run_frame(32'h0D0C0B0A, 1'b0, 32'hC3C2C1C0, 7'h59, 7, 32'h0D0C0B0A, 32'hC3C2C1C0, 1'b0);
        run_frame(32'h04030201, 1'b1, 32'hD3D2D1D0, 7'h0F, 4, 32'h01020304, 32'hD0D1D2D3, 1'b1);
        run_frame(32'hDEADBEEF, 1'b0, 32'hE3E2E1E0, 7'h0F, 4, 32'hDEADBEEF, 32'hE3E2E1E0, 1'b0);
        // Mid-frame reset: only the first shifted word is observed before reset lands.
        exp_so.push_back(8'h78);
        load_valid = 1'b1;
        load_data  = 32'h12345678;
        dir        = 1'b0;
        @(posedge clk); #1;
        load_valid = 1'b0;
        en = 1'b1;
        si = 8'h11;
        @(posedge clk); #1;
        si = 8'h22;
        @(posedge clk); #1;
        en   = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mrst_so", {24'd0, so}, 32'd0);
        chk("mrst_so_valid", {31'd0, so_valid}, 32'd0);
        chk("mrst_cap_data", cap_data, 32'd0);
        chk("mrst_cap_valid", {31'd0, cap_valid}, 32'd0);
        chk("mrst_ready", {31'd0, load_ready}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_frame(32'h88776655, 1'b0, 32'hB3B2B1B0, 7'h0F, 4, 32'h88776655, 32'hB3B2B1B0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("so_queue_drained", exp_so.size(), 32'd0);
        chk("cap_queue_drained", exp_cap.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sreg_xfer.md
# sreg_xfer

Parametrised full-duplex frame shifter: accepts an N-word parallel frame through a valid/ready handshake, serialises it W bits per enabled cycle, and simultaneously deserialises the incoming serial stream into a captured N-word frame. Shift direction (LSB-word-first or MSB-word-first) is selectable per frame. It sits between parallel datapath blocks and word-serial links, replacing fixed-direction, handshake-less shift registers.

## Interface
- N, 4, words per frame; N >= 2
- W, 1, word width in bits
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- load_valid  in  1  parallel frame offered
- load_ready  out  1  block can accept a frame (combinational from state)
- load_data  in  N*W  frame; word i = bits [(i+1)*W-1 : i*W]
- dir  in  1  0 = word 0 sent first, 1 = word N-1 sent first; sampled on load
- en  in  1  shift enable
- si  in  W  serial word in
- so  out  W  serial word out (registered)
- so_valid  out  1  so updated on the last edge (registered)
- cap_data  out  N*W  last fully received frame (registered)
- cap_valid  out  1  one-cycle pulse, cap_data just updated
- busy  out  1  frame in progress (state == SHIFT)

## Operation
- States: IDLE, SHIFT. Internal: word array ff[0..N-1], dir_q, counter cnt (0..N-1).
- IDLE: load_ready = 1. On an edge with load_valid = 1: ff <= load_data, dir_q <= dir, cnt <= 0, state -> SHIFT. en is ignored in IDLE; ff and so hold.
- SHIFT: load_ready = 0; load_valid is ignored (not accepted, not queued).
- On an edge in SHIFT with en = 1:
  - dir_q = 0: so <= ff[0]; ff[i] <= ff[i+1]; ff[N-1] <= si.
  - dir_q = 1: so <= ff[N-1]; ff[i] <= ff[i-1]; ff[0] <= si.
  - so_valid <= 1; cnt <= cnt + 1.
  - If cnt == N-1: cap_data <= the shifted-in ff contents, including the si word of this edge; cap_valid <= 1; state -> IDLE.
- On an edge in SHIFT with en = 0: ff, so, cnt hold; so_valid <= 0.
- so_valid and cap_valid are 0 on every edge that does not set them.
- Received ordering mirrors transmission ordering:
  - dir_q = 0: first si word lands in cap_data word 0.
  - dir_q = 1: first si word lands in cap_data word N-1.
- cap_data holds until the next completed frame.
- Reset (asynchronous, any time): ff = 0, so = 0, so_valid = 0, cap_data = 0, cap_valid = 0, cnt = 0, dir_q = 0, state = IDLE. Hence load_ready = 1 and busy = 0 during and after reset. An interrupted frame is discarded and produces no cap_valid.

## Timing
- Load accepted at edge k. With en = 1 continuously:
  - Words appear on so after edges k+1 .. k+N.
  - cap_valid is high for the cycle after edge k+N.
  - load_ready rises after edge k+N.
- Minimum frame period is N+1 cycles: one bubble between frames. No back-to-back load on the final shift edge.
- Latency from en = 1 to so update: 1 edge. Gaps in en stretch the frame 1:1.
- cnt width is clog2(N). cnt is compared to N-1 and never wraps past it.

## Structure
- Package sreg_pkg: state enum type (IDLE, SHIFT), direction constants (DIR_LSB_FIRST = 0, DIR_MSB_FIRST = 1).
- Single module; no sub-module. The FSM, counter and word array with generate-based neighbour muxing stay inline.

## Test plan
Settings for all scenarios: N = 4, W = 8.
- Reset: assert rstn = 0 mid-simulation -> so = 0, so_valid = 0, cap_data = 0, cap_valid = 0, load_ready = 1, busy = 0 immediately.
- LSB-first: load 0x44332211, dir = 0, en = 1, si = A0, A1, A2, A3 -> so = 11, 22, 33, 44 on 4 consecutive cycles with so_valid = 1; cap_data = 0xA3A2A1A0 with a single-cycle cap_valid; load_ready low exactly 4 cycles.
- MSB-first: same stimulus with dir = 1 -> so = 44, 33, 22, 11; cap_data = 0xA0A1A2A3.
- en gaps: en pattern 1,0,0,1,1,0,1 -> so holds across gaps; so_valid high only on the 4 enabled edges; cap_valid after the 7th edge.
- Load during SHIFT: load_valid = 1 with 0xDEADBEEF mid-frame -> not accepted and current frame unaffected; accepted on the first IDLE edge if still offered.
- Reset mid-frame: rstn low after 2 shifts -> no cap_valid; the next frame (0x88776655) shifts out correctly from word 0.
